// File: rtl/arbiter_pkg.sv
// Shared types and helpers for the NoC output-port round-robin arbiter.
package arbiter_pkg;

    localparam int MAX_PORTS = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } arb_state_e;

    // Width for a counter or index. It never returns 0, so a 1-entry range still gets one bit.
    function automatic int safe_clog2(input int v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

    function automatic logic [MAX_PORTS-1:0] onehot(input int idx, input int n);
        logic [MAX_PORTS-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_PORTS; i++) begin
            if (i == idx && i < n) v[i] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority pick: first set request at or after start, wrapping.
// The request vector is doubled so the wrap becomes a plain lowest-bit search.
module rr_pick #(
    parameter int N = 5,
    parameter int W = 3
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic [W-1:0] idx,
    output logic         valid
);

    logic [2*N-1:0] dbl;
    logic [2*N-1:0] masked;

    always_comb begin
        dbl    = {req, req};
        masked = '0;
        for (int i = 0; i < 2*N; i++) begin
            masked[i] = dbl[i] && (i >= int'(start));
        end
        idx   = '0;
        valid = |req;
        // Scan downward so the lowest qualifying bit is the one kept.
        for (int i = 2*N-1; i >= 0; i--) begin
            if (masked[i]) idx = (i >= N) ? W'(i - N) : W'(i);
        end
    end

endmodule

// File: rtl/arbiter_rr_param.sv
// Output-port arbiter: round-robin or fixed priority, burst limiting,
// RTS/DCTS handshake toward the downstream FIFO, and a one-hot crossbar select.
module arbiter_rr_param
    import arbiter_pkg::*;
#(
    parameter int NUM_PORTS  = 5,
    parameter int MAX_BURST  = 4,
    parameter int FIXED_PRIO = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] Req,
    input  logic                 DCTS,
    output logic                 RTS,
    output logic [NUM_PORTS-1:0] Grant,
    output logic [NUM_PORTS-1:0] Xbar_sel,
    output logic                 Busy
);

    localparam int IW = safe_clog2(NUM_PORTS);
    localparam int BW = safe_clog2(MAX_BURST + 1);
    localparam logic [IW-1:0] LAST = IW'(NUM_PORTS - 1);
    localparam logic [BW-1:0] BMAX = BW'(MAX_BURST);

    arb_state_e    state_q, state_d;
    logic [IW-1:0] cur_q, cur_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [BW-1:0] burst_q, burst_d;
    logic          rts_q, rts_d;

    logic [IW-1:0]        cur_inc;
    logic [IW-1:0]        pick_start;
    logic [IW-1:0]        pick_idx;
    logic                 pick_vld;
    logic [NUM_PORTS-1:0] cur_oh;
    logic                 stall;
    logic                 xfer;
    logic [BW-1:0]        burst_nxt;
    logic                 others;
    logic                 stay;

    assign cur_inc = (cur_q == LAST) ? '0 : cur_q + 1'b1;
    assign cur_oh  = NUM_PORTS'(onehot(int'(cur_q), NUM_PORTS));
    assign stall   = rts_q & ~DCTS;
    assign xfer    = rts_q & DCTS;

    // One picker is shared. IDLE resumes at ptr, ACTIVE moves on from cur+1, and fixed priority always starts at 0.
    always_comb begin
        pick_start = '0;
        if (FIXED_PRIO == 0) pick_start = (state_q == IDLE) ? ptr_q : cur_inc;
    end

    rr_pick #(.N(NUM_PORTS), .W(IW)) u_pick (
        .req   (Req),
        .start (pick_start),
        .idx   (pick_idx),
        .valid (pick_vld)
    );

    always_comb begin
        burst_nxt = burst_q;
        if (xfer && burst_q != BMAX) burst_nxt = burst_q + 1'b1;
        others = |(Req & ~cur_oh);
        stay   = Req[cur_q] && ((MAX_BURST == 0) || (burst_nxt < BMAX) || !others);
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        ptr_d   = ptr_q;
        burst_d = burst_q;
        if (!stall) begin
            case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        state_d = ACTIVE;
                        cur_d   = pick_idx;
                        burst_d = '0;
                    end
                end
                ACTIVE: begin
                    if (FIXED_PRIO != 0) begin
                        if (pick_vld) cur_d = pick_idx;
                        else          state_d = IDLE;
                    end else if (stay) begin
                        burst_d = burst_nxt;
                    end else begin
                        ptr_d = cur_inc;
                        if (pick_vld) begin
                            cur_d   = pick_idx;
                            burst_d = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        // An accepted transfer forces one RTS-low cycle. That gap is where switching normally happens.
        rts_d = (state_d == ACTIVE) && !xfer;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cur_q   <= '0;
            ptr_q   <= '0;
            burst_q <= '0;
            rts_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            ptr_q   <= ptr_d;
            burst_q <= burst_d;
            rts_q   <= rts_d;
        end
    end

    assign Busy     = (state_q == ACTIVE);
    assign RTS      = rts_q;
    assign Xbar_sel = Busy ? cur_oh : '0;
    assign Grant    = (Busy && xfer) ? cur_oh : '0;

endmodule

// File: tb/tb_arbiter_rr_param.sv
// Scoreboard bench for three arbiter configurations against a rule-level model.
module tb_arbiter_rr_param;

    typedef struct packed {
        logic        rts;
        logic        busy;
        logic [15:0] xbar;
        logic [15:0] grant;
    } exp_t;

    typedef struct {
        bit act;
        int cur;
        int ptr;
        int bc;
        bit rts;
    } mst_t;

    logic       clk;
    logic       rst;
    logic       dcts;
    logic [4:0] req0, req1;
    logic [2:0] req2;
    logic       rts0, rts1, rts2, busy0, busy1, busy2;
    logic [4:0] gnt0, gnt1, xs0, xs1;
    logic [2:0] gnt2, xs2;

    int checks = 0;
    int fails  = 0;
    exp_t q0[$], q1[$], q2[$];
    mst_t m[3];
    int   np[3] = '{5, 5, 3};
    int   mb[3] = '{4, 0, 4};
    bit   fp[3] = '{0, 0, 1};

    arbiter_rr_param #(.NUM_PORTS(5), .MAX_BURST(4), .FIXED_PRIO(0)) u0 (
        .clk(clk), .rst(rst), .Req(req0), .DCTS(dcts), .RTS(rts0),
        .Grant(gnt0), .Xbar_sel(xs0), .Busy(busy0));
    arbiter_rr_param #(.NUM_PORTS(5), .MAX_BURST(0), .FIXED_PRIO(0)) u1 (
        .clk(clk), .rst(rst), .Req(req1), .DCTS(dcts), .RTS(rts1),
        .Grant(gnt1), .Xbar_sel(xs1), .Busy(busy1));
    arbiter_rr_param #(.NUM_PORTS(3), .MAX_BURST(4), .FIXED_PRIO(1)) u2 (
        .clk(clk), .rst(rst), .Req(req2), .DCTS(dcts), .RTS(rts2),
        .Grant(gnt2), .Xbar_sel(xs2), .Busy(busy2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pick(input logic [15:0] r, input int start, input int n);
        for (int k = 0; k < n; k++) begin
            if (r[(start + k) % n]) return (start + k) % n;
        end
        return 0;
    endfunction

    function automatic exp_t expect_of(input mst_t s, input bit d);
        exp_t e;
        e.rts   = s.rts;
        e.busy  = s.act;
        e.xbar  = s.act ? (16'd1 << s.cur) : 16'd0;
        e.grant = (s.act && s.rts && d) ? (16'd1 << s.cur) : 16'd0;
        return e;
    endfunction

    function automatic mst_t step(input mst_t s, input int n, input int lim, input bit fx,
                                  input logic [15:0] r, input bit d);
        mst_t t;
        bit   g;
        int   bn;
        bit   others;
        t = s;
        g = s.rts && d;
        if (s.rts && !d) return s;
        if (!s.act) begin
            if (r != 0) begin
                t.act = 1;
                t.cur = pick(r, fx ? 0 : s.ptr, n);
                t.bc  = 0;
            end
        end else if (fx) begin
            if (r != 0) t.cur = pick(r, 0, n);
            else        t.act = 0;
        end else begin
            bn     = g ? ((s.bc < lim) ? s.bc + 1 : lim) : s.bc;
            others = (r & ~(16'd1 << s.cur)) != 0;
            if (r[s.cur] && (lim == 0 || bn < lim || !others)) begin
                t.bc = bn;
            end else begin
                t.ptr = (s.cur + 1) % n;
                if (r != 0) begin
                    t.cur = pick(r, t.ptr, n);
                    t.bc  = 0;
                end else begin
                    t.act = 0;
                end
            end
        end
        t.rts = t.act && !g;
        return t;
    endfunction

    function automatic exp_t mk(input logic r, input logic b, input logic [15:0] x, input logic [15:0] g);
        exp_t e;
        e.rts = r; e.busy = b; e.xbar = x; e.grant = g;
        return e;
    endfunction

    task automatic chk(input int id, input exp_t a);
        exp_t e;
        int   sz;
        sz = (id == 0) ? q0.size() : (id == 1) ? q1.size() : q2.size();
        checks++;
        if (sz == 0) begin
            fails++;
            $display("FAIL sb_empty u%0d t=%0t: DUT output with no expected entry", id, $time);
            return;
        end
        case (id)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
        if (a !== e) begin
            fails++;
            $display("FAIL cycle u%0d t=%0t got rts=%b busy=%b xbar=%h grant=%h want rts=%b busy=%b xbar=%h grant=%h",
                     id, $time, a.rts, a.busy, a.xbar, a.grant, e.rts, e.busy, e.xbar, e.grant);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            assert (!$isunknown({req0, req1, req2})) else $error("FAIL req_x: X on Req");
            chk(0, mk(rts0, busy0, {11'd0, xs0}, {11'd0, gnt0}));
            chk(1, mk(rts1, busy1, {11'd0, xs1}, {11'd0, gnt1}));
            chk(2, mk(rts2, busy2, {13'd0, xs2}, {13'd0, gnt2}));
        end
    end

    // Drive one cycle. The expected outputs are queued from the model's present state, then the model advances.
    task automatic cyc(input logic [4:0] r, input bit d);
        logic [15:0] rm;
        req0 = r;
        req1 = r;
        req2 = r[2:0];
        dcts = d;
        for (int i = 0; i < 3; i++) begin
            rm = (i == 2) ? {13'd0, r[2:0]} : {11'd0, r};
            case (i)
                0:       q0.push_back(expect_of(m[i], d));
                1:       q1.push_back(expect_of(m[i], d));
                default: q2.push_back(expect_of(m[i], d));
            endcase
            m[i] = step(m[i], np[i], mb[i], fp[i], rm, d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m[i] = '{0, 0, 0, 0, 0};
        q0.delete();
        q1.delete();
        q2.delete();
    endtask

    task automatic chk_zero(input string nm);
        checks++;
        if ({rts0, busy0, xs0, gnt0, rts1, busy1, xs1, gnt1, rts2, busy2, xs2, gnt2} !== '0) begin
            fails++;
            $display("FAIL %s got rts=%b%b%b busy=%b%b%b xbar=%h/%h/%h grant=%h/%h/%h want all zero",
                     nm, rts0, rts1, rts2, busy0, busy1, busy2, xs0, xs1, xs2, gnt0, gnt1, gnt2);
        end
    endtask

    initial begin
        logic [4:0] rr;
        rst  = 1'b1;
        dcts = 1'b0;
        req0 = '0; req1 = '0; req2 = '0;
        model_reset();
        #1;
        chk_zero("reset_state");
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        repeat (3) cyc(5'b00000, 1'b1);
        repeat (12) cyc(5'b00100, 1'b1);
        repeat (3) cyc(5'b00000, 1'b1);

        // Fairness: every fourth cycle, drop the request that the unlimited-burst instance is serving.
        for (int k = 0; k < 40; k++) begin
            rr = 5'b11111;
            if (m[1].act && (k % 4 == 3)) rr[m[1].cur] = 1'b0;
            cyc(rr, 1'b1);
        end
        repeat (3) cyc(5'b00000, 1'b1);

        repeat (30) cyc(5'b00011, 1'b1);
        repeat (3) cyc(5'b00000, 1'b1);

        repeat (2) cyc(5'b01000, 1'b1);
        repeat (10) cyc(5'b00001, 1'b0);
        repeat (6) cyc(5'b00001, 1'b1);
        repeat (3) cyc(5'b00000, 1'b1);

        repeat (4) cyc(5'b00110, 1'b1);
        repeat (12) cyc(5'b00111, 1'b1);
        repeat (3) cyc(5'b00000, 1'b1);

        // Assert reset mid-cycle while RTS is high. The outputs must clear without a clock edge.
        repeat (3) cyc(5'b11111, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk_zero("async_reset");
        model_reset();
        req0 = '0; req1 = '0; req2 = '0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) cyc(5'b00000, 1'b1);

        rr = 5'b00000;
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 5) == 0) rr = 5'($urandom_range(0, 31));
            cyc(rr, $urandom_range(0, 3) != 0);
        end
        cyc(5'b00000, 1'b1);

        checks++;
        if (q0.size() + q1.size() + q2.size() != 0) begin
            fails++;
            $display("FAIL sb_drain got %0d leftover entries want 0", q0.size() + q1.size() + q2.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/arbiter_rr_param.md
Name: arbiter_rr_param

Overview:
- Parametrised output-port arbiter for the NoC router; successor to the fixed 5-input, fixed-rotation arbiter.
- Arbitrates NUM_PORTS input requests for one output port using a rotating round-robin pointer and an optional per-grant burst limit for starvation control.
- Drives a one-hot crossbar select and runs the RTS/DCTS flow-control handshake toward the downstream FIFO.
- One instance per router output; Xbar_sel feeds the crossbar mux directly.

Parameters:
- NUM_PORTS, 5, number of requesting inputs (2..16). Index 0 is Local; 1..4 are N/E/W/S in the 5-port router.
- MAX_BURST, 4, consecutive accepted transfers allowed to one input while others request. 0 = unlimited.
- FIXED_PRIO, 0, 1 = fixed priority (index 0 highest) with no pointer rotation and MAX_BURST ignored. 0 = round-robin.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- Req  in  NUM_PORTS  request per input, level, held until served.
- DCTS  in  1  downstream clear-to-send.
- RTS  out  1  request-to-send, registered.
- Grant  out  NUM_PORTS  one-hot transfer grant, combinational: Grant[cur] = RTS & DCTS while ACTIVE.
- Xbar_sel  out  NUM_PORTS  one-hot select of cur while ACTIVE; all zeros in IDLE.
- Busy  out  1  high while ACTIVE.

Behaviour:
- Reset (async) values:
  - state = IDLE, cur = 0, ptr = 0, burst_cnt = 0, RTS = 0.
  - Grant, Xbar_sel and Busy are all 0.
- Registers: state {IDLE, ACTIVE}, cur [clog2(NUM_PORTS)], ptr (round-robin start index), burst_cnt [clog2(MAX_BURST+1)], RTS.
- RTS next value:
  - 0 if the next state is IDLE.
  - 0 if RTS & DCTS this cycle; the transfer is accepted and RTS drops for one cycle.
  - 1 otherwise.
  - Consequence: at most one transfer per two cycles, and RTS stays high until DCTS is seen.
- Stall: while RTS & !DCTS, state, cur, ptr and burst_cnt hold. Req changes are ignored until the stall releases.
- Selection function pick(start): lowest index i such that Req[(start+k) mod NUM_PORTS] is set, scanning k = 0..NUM_PORTS-1. Wrap-around is explicit; NUM_PORTS need not be a power of 2.
- IDLE, when not stalled:
  - If any Req: go ACTIVE, cur = pick(ptr), or pick(0) if FIXED_PRIO; burst_cnt = 0.
  - Else stay IDLE.
- ACTIVE, when not stalled:
  - Grant event: burst_cnt increments, saturating at MAX_BURST.
  - Stay condition: Req[cur] and (MAX_BURST == 0 or burst_cnt_next < MAX_BURST or no other Req set). If true, cur is held.
  - Otherwise, with any Req set: cur = pick(cur+1); ptr = cur+1 mod NUM_PORTS; burst_cnt = 0.
  - Otherwise, no Req: go IDLE; ptr = cur+1 mod NUM_PORTS.
  - FIXED_PRIO=1: next cur = pick(0) whenever Req is nonzero, else IDLE; no pointer update.
- Latency:
  - Req rising in IDLE gives Xbar_sel/Busy on the next edge and RTS on the same edge.
  - The first Grant occurs in the first cycle where DCTS = 1 while RTS = 1.
- Switching rule: the switch is evaluated every unstalled cycle. The RTS-low cycle after a grant is the normal switch point, so a switch never occurs while a transfer is pending.
- Req dropping mid-ACTIVE while stalled has no effect until DCTS; the pending transfer still completes for cur.
- Invariants: Grant and Xbar_sel are one-hot or zero; Grant is a subset of Xbar_sel; Grant is never set in IDLE.
- An X on Req in IDLE is a bench error (assertion); the RTL need not tolerate it.

Decomposition:
- Package arbiter_pkg:
  - state enum (IDLE, ACTIVE).
  - function onehot(idx, n).
  - function clog2-safe width helper.
- Sub-module rr_pick:
  - Purely combinational.
  - Inputs: Req vector and start index. Outputs: index and valid.
  - Implemented as double-width masked priority encode.
  - Instantiated once in the top, shared by IDLE and ACTIVE selection.

Test Plan:
- Reset mid-operation: rst asserted asynchronously while ACTIVE with RTS=1 -> RTS, Busy, Grant, Xbar_sel are 0 immediately without a clock edge; after release with Req=0 -> stays IDLE.
- Single requester (default params): Req=00100, DCTS=1 -> Xbar_sel=00100 one cycle later; Grant=00100 on alternate cycles (RTS toggling 1,0,1,0); state never leaves input 2.
- Round-robin fairness: Req=11111, DCTS=1, MAX_BURST=0, ptr=0 -> after the first switch triggered by dropping the current Req, service order is 0,1,2,3,4,0 with no input repeated before all others are served.
- Burst limit: MAX_BURST=4, Req=00011 held, DCTS=1 -> input 0 receives exactly 4 Grants, then Xbar_sel=00010 for 4 Grants, then back to 00001.
- DCTS stall: ACTIVE on input 3, DCTS=0 for 10 cycles while Req changes to 00001 -> RTS stays 1, Xbar_sel stays 01000, Grant=0; DCTS=1 -> one Grant=01000, then switch to input 0.
- FIXED_PRIO=1, NUM_PORTS=3: Req=110 then Req=111 -> cur=1, then cur=0 after the next unstalled cycle; input 0 keeps priority indefinitely and input 2 is never served while Req[0] or Req[1] is set.
